wb_stage: RTL and testbench

- Write-back stage; the producer side of the register-file write port that the decode stage consumes.
- Accepts retiring instructions from the memory stage over a valid/ready handshake and waits for load data from data memory when needed.
- Drives the register-file write controls: RF_WrEn, write_register, ALU_out, MEM_out and RF_WrData_sel.
- Publishes forwarding and load-pending hazard information back to decode.

---
 rtl/wb_pkg.sv | 15 +
 rtl/wb_timeout_ctr.sv | 33 +++
 rtl/wb_stage.sv | 134 +++++++++++++
 tb/tb_wb_stage.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and constants for the write-back stage
package wb_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } wb_state_t;

endpackage

// File: rtl/wb_timeout_ctr.sv
// rtl/wb_timeout_ctr.sv - loadable up-counter with clear, enable and terminal-count flag
module wb_timeout_ctr #(
  parameter int             W  = 5,
  parameter logic [W-1:0]   TC = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         en,
  output logic         tc
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (ld) begin
      cnt <= ld_val;
    end else if (en) begin
      cnt <= cnt + ONE;
    end
  end

  assign tc = (cnt == TC);

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - write-back stage driving the register-file write port
// WB_FORWARD_EN: when defined, fwd_* mirror the registered write controls.
module wb_stage
  import wb_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [REG_W-1:0]  in_rd,
  input  logic              in_wr_en,
  input  logic              in_is_load,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              RF_WrEn,
  output logic [REG_W-1:0]  write_register,
  output logic [DATA_W-1:0] ALU_out,
  output logic [DATA_W-1:0] MEM_out,
  output logic              RF_WrData_sel,
  output logic              load_pending,
  output logic [REG_W-1:0]  pending_reg,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_reg,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  retired_cnt,
  output logic              mem_err
);

  localparam int               TO_W    = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [TO_W-1:0]  TO_TC   = TO_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  wb_state_t          state;
  logic [REG_W-1:0]   rd_q;
  logic               wr_en_q;
  logic               xfer;
  logic               to_tc;

  assign in_ready = (state != WAIT_MEM);
  assign xfer     = in_valid && in_ready;

  wb_timeout_ctr #(
    .W  (TO_W),
    .TC (TO_TC)
  ) u_timeout (
    .clk    (Clk),
    .rst    (Reset),
    .clr    (xfer && in_is_load),
    .ld     (1'b0),
    .ld_val ('0),
    .en     ((state == WAIT_MEM) && !mem_rvalid && !to_tc),
    .tc     (to_tc)
  );

  // RF_WrEn is registered so it is high exactly while the state is WRITE.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state          <= IDLE;
      rd_q           <= REG_ZERO;
      wr_en_q        <= 1'b0;
      RF_WrEn        <= 1'b0;
      write_register <= REG_ZERO;
      ALU_out        <= '0;
      MEM_out        <= '0;
      RF_WrData_sel  <= 1'b0;
      load_pending   <= 1'b0;
      pending_reg    <= REG_ZERO;
      retired_cnt    <= '0;
      mem_err        <= 1'b0;
    end else begin
      RF_WrEn <= 1'b0;
      case (state)
        IDLE, WRITE: begin
          if (xfer) begin
            rd_q        <= in_rd;
            wr_en_q     <= in_wr_en;
            ALU_out     <= in_alu;
            retired_cnt <= retired_cnt + CNT_ONE;
            if (in_is_load) begin
              state        <= WAIT_MEM;
              load_pending <= 1'b1;
              pending_reg  <= in_rd;
            end else if (in_wr_en && in_rd != REG_ZERO) begin
              state          <= WRITE;
              RF_WrEn        <= 1'b1;
              write_register <= in_rd;
              RF_WrData_sel  <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT_MEM: begin
          if (mem_rvalid) begin
            MEM_out      <= mem_rdata;
            load_pending <= 1'b0;
            pending_reg  <= REG_ZERO;
            if (wr_en_q && rd_q != REG_ZERO) begin
              state          <= WRITE;
              RF_WrEn        <= 1'b1;
              write_register <= rd_q;
              RF_WrData_sel  <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (to_tc) begin
            mem_err      <= 1'b1;
            load_pending <= 1'b0;
            pending_reg  <= REG_ZERO;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WB_FORWARD_EN
  assign fwd_valid = RF_WrEn;
  assign fwd_reg   = write_register;
  assign fwd_data  = RF_WrData_sel ? MEM_out : ALU_out;
`else
  assign fwd_valid = 1'b0;
  assign fwd_reg   = REG_ZERO;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage against a transaction-level model
module tb_wb_stage;

  localparam int MEM_TIMEOUT = 16;
  localparam int CNT_W       = 16;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_alu;
  logic [4:0]  in_rd;
  logic        in_wr_en;
  logic        in_is_load;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        RF_WrEn;
  logic [4:0]  write_register;
  logic [31:0] ALU_out;
  logic [31:0] MEM_out;
  logic        RF_WrData_sel;
  logic        load_pending;
  logic [4:0]  pending_reg;
  logic        fwd_valid;
  logic [4:0]  fwd_reg;
  logic [31:0] fwd_data;
  logic [15:0] retired_cnt;
  logic        mem_err;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  wb_stage #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_alu(in_alu), .in_rd(in_rd), .in_wr_en(in_wr_en), .in_is_load(in_is_load),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .RF_WrEn(RF_WrEn),
    .write_register(write_register), .ALU_out(ALU_out), .MEM_out(MEM_out),
    .RF_WrData_sel(RF_WrData_sel), .load_pending(load_pending), .pending_reg(pending_reg),
    .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
    .retired_cnt(retired_cnt), .mem_err(mem_err)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a load is either outstanding or not; a write is due after a retiring
  // writer or after load data arrives; an outstanding load gives up after
  // MEM_TIMEOUT data-less cycles.
  bit          m_pending;
  logic [4:0]  m_prd;
  bit          m_pwr;
  int          m_waited;
  bit          m_wr;
  logic [4:0]  m_wreg;
  bit          m_sel;
  logic [31:0] m_alu, m_mem;
  logic [15:0] m_cnt;
  bit          m_err;

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_pending = 0; m_prd = 0; m_pwr = 0; m_waited = 0; m_wr = 0; m_wreg = 0;
      m_sel = 0; m_alu = 0; m_mem = 0; m_cnt = 0; m_err = 0;
    end else begin
      m_wr = 0;
      if (!m_pending) begin
        if (in_valid) begin
          m_cnt = m_cnt + 16'd1;
          m_alu = in_alu;
          if (in_is_load) begin
            m_pending = 1; m_prd = in_rd; m_pwr = in_wr_en; m_waited = 0;
          end else if (in_wr_en && in_rd != 0) begin
            m_wr = 1; m_wreg = in_rd; m_sel = 0;
          end
        end
      end else if (mem_rvalid) begin
        m_mem = mem_rdata;
        m_pending = 0;
        if (m_pwr && m_prd != 0) begin
          m_wr = 1; m_wreg = m_prd; m_sel = 1;
        end
      end else begin
        m_waited++;
        if (m_waited == MEM_TIMEOUT) begin
          m_err = 1; m_pending = 0;
        end
      end
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      chk("in_ready", 32'(in_ready), 32'(!m_pending));
      chk("RF_WrEn", 32'(RF_WrEn), 32'(m_wr));
      chk("write_register", 32'(write_register), 32'(m_wreg));
      chk("RF_WrData_sel", 32'(RF_WrData_sel), 32'(m_sel));
      chk("ALU_out", ALU_out, m_alu);
      chk("MEM_out", MEM_out, m_mem);
      chk("load_pending", 32'(load_pending), 32'(m_pending));
      if (m_pending) chk("pending_reg", 32'(pending_reg), 32'(m_prd));
      chk("retired_cnt", 32'(retired_cnt), 32'(m_cnt));
      chk("mem_err", 32'(mem_err), 32'(m_err));
`ifdef WB_FORWARD_EN
      chk("fwd_valid", 32'(fwd_valid), 32'(m_wr));
      chk("fwd_reg", 32'(fwd_reg), 32'(m_wreg));
      chk("fwd_data", fwd_data, m_sel ? m_mem : m_alu);
`else
      chk("fwd_valid", 32'(fwd_valid), 32'd0);
      chk("fwd_reg", 32'(fwd_reg), 32'd0);
      chk("fwd_data", fwd_data, 32'd0);
`endif
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge Clk);
      #2;
    end
  endtask

  task automatic send(input logic [31:0] alu, input logic [4:0] rd, input logic wr, input logic ld);
    in_valid = 1; in_alu = alu; in_rd = rd; in_wr_en = wr; in_is_load = ld;
  endtask

  initial begin
    Reset = 1; in_valid = 0; in_alu = 0; in_rd = 0; in_wr_en = 0; in_is_load = 0;
    mem_rvalid = 0; mem_rdata = 0;
    cyc(2);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_wren", 32'(RF_WrEn), 32'd0);
    chk("rst_cnt", 32'(retired_cnt), 32'd0);
    Reset = 0;
    chk_en = 1;

    // ALU write
    send(32'h1234, 5'd5, 1, 0); cyc(); in_valid = 0;
    chk("alu_wren", 32'(RF_WrEn), 32'd1);
    chk("alu_reg", 32'(write_register), 32'd5);
    chk("alu_sel", 32'(RF_WrData_sel), 32'd0);
    chk("alu_out", ALU_out, 32'h1234);
    chk("alu_cnt", 32'(retired_cnt), 32'd1);
    cyc();
    chk("alu_single", 32'(RF_WrEn), 32'd0);

    // load with data three cycles after acceptance
    send(32'h100, 5'd8, 1, 1); cyc(); in_valid = 0;
    chk("ld_pending", 32'(load_pending), 32'd1);
    chk("ld_preg", 32'(pending_reg), 32'd8);
    chk("ld_ready", 32'(in_ready), 32'd0);
    cyc(2);
    mem_rvalid = 1; mem_rdata = 32'hDEADBEEF; cyc(); mem_rvalid = 0;
    chk("ld_wren", 32'(RF_WrEn), 32'd1);
    chk("ld_mem", MEM_out, 32'hDEADBEEF);
    chk("ld_sel", 32'(RF_WrData_sel), 32'd1);
    chk("ld_reg", 32'(write_register), 32'd8);

    // register 0
    send(32'h77, 5'd0, 1, 0); cyc(); in_valid = 0;
    chk("r0_wren", 32'(RF_WrEn), 32'd0);
    chk("r0_cnt", 32'(retired_cnt), 32'd3);

    // back-to-back writes
    for (int i = 1; i <= 3; i++) begin
      send(32'h10 + 32'(i), 5'(i), 1, 0); cyc();
      chk("b2b_wren", 32'(RF_WrEn), 32'd1);
      chk("b2b_reg", 32'(write_register), 32'(i));
    end
    in_valid = 0; cyc();
    chk("b2b_end", 32'(RF_WrEn), 32'd0);

    // stray mem_rvalid while idle
    mem_rvalid = 1; mem_rdata = 32'h5555; cyc(); mem_rvalid = 0;
    chk("stray_mem", MEM_out, 32'hDEADBEEF);

    // timeout
    send(32'h200, 5'd9, 1, 1); cyc(); in_valid = 0;
    cyc(MEM_TIMEOUT - 1);
    chk("to_not_yet", 32'(mem_err), 32'd0);
    cyc();
    chk("to_err", 32'(mem_err), 32'd1);
    chk("to_ready", 32'(in_ready), 32'd1);
    mem_rvalid = 1; mem_rdata = 32'h6666; cyc(); mem_rvalid = 0;
    chk("to_late", 32'(RF_WrEn), 32'd0);

    // immediate load data followed by a write straight from WRITE
    send(32'h300, 5'd10, 1, 1); cyc(); in_valid = 0;
    mem_rvalid = 1; mem_rdata = 32'hA5A5A5A5; cyc(); mem_rvalid = 0;
    chk("fast_ld_reg", 32'(write_register), 32'd10);
    send(32'h400, 5'd11, 1, 0); cyc(); in_valid = 0;
    chk("wr_after_ld", 32'(RF_WrEn), 32'd1);
    chk("wr_after_ld_reg", 32'(write_register), 32'd11);
    cyc();

    // reset while waiting for memory
    send(32'h500, 5'd12, 1, 1); cyc(); in_valid = 0; cyc();
    Reset = 1; #1;
    chk("rw_ready", 32'(in_ready), 32'd1);
    chk("rw_pending", 32'(load_pending), 32'd0);
    chk("rw_cnt", 32'(retired_cnt), 32'd0);
    chk("rw_err", 32'(mem_err), 32'd0);
    cyc(); Reset = 0;
    mem_rvalid = 1; mem_rdata = 32'h7777; cyc(); mem_rvalid = 0;
    chk("rw_late", 32'(RF_WrEn), 32'd0);

    // data arriving on the last allowed wait cycle wins over the timeout
    send(32'h600, 5'd13, 1, 1); cyc(); in_valid = 0;
    cyc(MEM_TIMEOUT - 1);
    mem_rvalid = 1; mem_rdata = 32'h0BADF00D; cyc(); mem_rvalid = 0;
    chk("edge_wren", 32'(RF_WrEn), 32'd1);
    chk("edge_err", 32'(mem_err), 32'd0);
    chk("edge_mem", MEM_out, 32'h0BADF00D);
    cyc(2);

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
